// File: rtl/tile_loader_pkg.sv
// Shared constants and types for the tile loader: command codes, grid size, FSM states.
package tile_pkg;

  localparam logic [7:0] CMD_SET_ADDR = 8'h80;
  localparam logic [7:0] CMD_WRITE    = 8'h81;
  localparam logic [7:0] CMD_FILL     = 8'h82;

  // 20x15 tile grid
  localparam int CELLS_DEFAULT  = 300;
  localparam int ADDR_W_DEFAULT = 9;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_HI,
    ADDR_LO,
    COUNT,
    DATA,
    FILL
  } state_t;

endpackage

// File: rtl/tile_loader_if.sv
// Byte stream in, tile RAM write port and status out.
// The master side feeds command bytes; the slave side is the loader.
interface tile_loader_if #(
  parameter int ADDR_W = tile_pkg::ADDR_W_DEFAULT
);

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;
  logic              busy;
  logic              err;

  modport master (
    output in_data, in_valid,
    input  in_ready, we, addr, wdata, busy, err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, we, addr, wdata, busy, err
  );

endinterface

// File: rtl/tile_loader.sv
// Tile loader: decodes a byte command stream (SET_ADDR / WRITE / FILL) into
// registered tile RAM writes. One write per cycle, one cycle after the byte
// that causes it. FILL blocks the input stream until every cell is written.
module tile_loader
  import tile_pkg::*;
#(
  parameter int CELLS  = CELLS_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  tile_loader_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  state_t            state, state_next;
  logic              is_fill, is_fill_next;
  logic [7:0]        addr_hi, addr_hi_next;
  logic [ADDR_W-1:0] ptr, ptr_next;
  logic [8:0]        count, count_next;
  logic [7:0]        colour, colour_next;
  logic              fill_done, fill_done_next;
  logic              we_q, we_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic [7:0]        wdata_q, wdata_next;
  logic              err_q, err_next;

  logic              in_ready_int;
  logic              accept;
  logic [15:0]       addr_word;
  logic [ADDR_W-1:0] ptr_inc;

  // Input is only stalled while FILL is sweeping the grid.
  assign in_ready_int = (state != FILL);
  assign accept       = bus.in_valid & in_ready_int;
  assign addr_word    = {addr_hi, bus.in_data};
  assign ptr_inc      = (ptr == LAST_CELL) ? '0 : ptr + ADDR_W'(1);

  assign bus.in_ready = in_ready_int;
  assign bus.busy     = (state != IDLE);
  assign bus.we       = we_q;
  assign bus.addr     = addr_q;
  assign bus.wdata    = wdata_q;
  assign bus.err      = err_q;

  // Next-state and next-register logic; the write strobe and error are
  // single-cycle pulses, while addr/wdata hold until the next write.
  always_comb begin
    state_next     = state;
    is_fill_next   = is_fill;
    addr_hi_next   = addr_hi;
    ptr_next       = ptr;
    count_next     = count;
    colour_next    = colour;
    fill_done_next = fill_done;
    we_next        = 1'b0;
    addr_next      = addr_q;
    wdata_next     = wdata_q;
    err_next       = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          case (bus.in_data)
            CMD_SET_ADDR: state_next = ADDR_HI;
            CMD_WRITE: begin
              is_fill_next = 1'b0;
              state_next   = COUNT;
            end
            CMD_FILL: begin
              is_fill_next = 1'b1;
              state_next   = COUNT;
            end
            default: err_next = 1'b1;
          endcase
        end
      end

      ADDR_HI: begin
        if (accept) begin
          addr_hi_next = bus.in_data;
          state_next   = ADDR_LO;
        end
      end

      ADDR_LO: begin
        if (accept) begin
          // An address outside the grid parks the pointer at cell 0.
          if (32'(addr_word) >= CELLS) begin
            ptr_next = '0;
            err_next = 1'b1;
          end else begin
            ptr_next = addr_word[ADDR_W-1:0];
          end
          state_next = IDLE;
        end
      end

      COUNT: begin
        if (accept) begin
          if (is_fill) begin
            colour_next    = bus.in_data;
            ptr_next       = '0;
            fill_done_next = 1'b0;
            state_next     = FILL;
          end else begin
            // A count byte of zero stands for a full 256-byte burst.
            count_next = (bus.in_data == 8'd0) ? 9'd256 : {1'b0, bus.in_data};
            state_next = DATA;
          end
        end
      end

      DATA: begin
        if (accept) begin
          we_next    = 1'b1;
          addr_next  = ptr;
          wdata_next = bus.in_data;
          ptr_next   = ptr_inc;
          count_next = count - 9'd1;
          if (count == 9'd1) begin
            state_next = IDLE;
          end
        end
      end

      FILL: begin
        // After the last cell we linger one cycle so in_ready stays low
        // for every fill write, including the final one.
        if (fill_done) begin
          fill_done_next = 1'b0;
          state_next     = IDLE;
        end else begin
          we_next    = 1'b1;
          addr_next  = ptr;
          wdata_next = colour;
          ptr_next   = ptr_inc;
          if (ptr == LAST_CELL) begin
            fill_done_next = 1'b1;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any burst or fill at once.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      is_fill   <= 1'b0;
      addr_hi   <= '0;
      ptr       <= '0;
      count     <= '0;
      colour    <= '0;
      fill_done <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      is_fill   <= is_fill_next;
      addr_hi   <= addr_hi_next;
      ptr       <= ptr_next;
      count     <= count_next;
      colour    <= colour_next;
      fill_done <= fill_done_next;
      we_q      <= we_next;
      addr_q    <= addr_next;
      wdata_q   <= wdata_next;
      err_q     <= err_next;
    end
  end

endmodule

// File: tb/tb_tile_loader.sv
// Scoreboard bench for tile_loader: command-level reference model pushes
// expected writes/errors, an independent monitor compares what the DUT emits.
module tb_tile_loader;
  import tile_pkg::*;

  localparam int CELLS  = 300;
  localparam int ADDR_W = 9;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  tile_loader_if #(.ADDR_W(ADDR_W)) bus();

  tile_loader #(.CELLS(CELLS), .ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
    bit fill;
    bit b2b;
  } wr_t;

  wr_t exp_q[$];
  int  payload[$];
  wr_t cur;
  int  exp_err = 0;
  int  checks = 0;
  int  errors = 0;
  int  mptr = 0;
  int  cycle = 0;
  int  last_we_cycle = -10;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic report_fail(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: %s", name, what);
  endtask

  // Monitor: every write strobe and error pulse is matched against the model.
  always @(negedge clk) begin
    cycle++;
    if (reset_n) begin
      if (bus.we === 1'b1) begin
        if (exp_q.size() == 0) begin
          report_fail("unexpected_we", $sformatf("addr=%0d wdata=0x%0h, none expected", bus.addr, bus.wdata));
        end else begin
          cur = exp_q.pop_front();
          checkOutput("wr_addr", 32'(bus.addr), cur.addr);
          checkOutput("wr_data", 32'(bus.wdata), cur.data);
          if (cur.fill) begin
            checkOutput("fill_in_ready", 32'(bus.in_ready), 0);
            checkOutput("fill_busy", 32'(bus.busy), 1);
          end
          if (cur.b2b) checkOutput("wr_spacing", cycle - last_we_cycle, 1);
        end
        last_we_cycle = cycle;
      end else if (bus.we !== 1'b0) begin
        report_fail("we_unknown", "we is X/Z");
      end
      if (bus.err === 1'b1) begin
        if (exp_err > 0) begin
          checks++;
          exp_err--;
        end else begin
          report_fail("unexpected_err", "err pulsed with none expected");
        end
      end
    end
  end

  // Present one byte after 'gap' idle cycles; returns just after the accept edge.
  task automatic applyStimulus(input int b, input int gap);
    int waited;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_data  = 8'(b);
    bus.in_valid = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      waited++;
      if (waited > 2000) begin
        report_fail("in_ready_timeout", $sformatf("byte 0x%0h never accepted", b));
        bus.in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cmd_set_addr(input int hi, input int lo);
    int v;
    v = hi * 256 + lo;
    if (v >= CELLS) begin
      mptr = 0;
      exp_err++;
    end else begin
      mptr = v;
    end
    applyStimulus(8'h80, 0);
    applyStimulus(hi, 0);
    applyStimulus(lo, 0);
  endtask

  // Sends the bytes queued in payload as one WRITE burst.
  task automatic cmd_write(input int gapmax);
    int n, g, b;
    n = payload.size();
    applyStimulus(8'h81, 0);
    applyStimulus(n % 256, 0);
    for (int i = 0; i < n; i++) begin
      b = payload[i];
      g = (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0;
      exp_q.push_back('{addr: mptr, data: b, fill: 1'b0, b2b: (i > 0 && g == 0)});
      mptr = (mptr + 1) % CELLS;
      applyStimulus(b, g);
    end
    payload.delete();
  endtask

  task automatic cmd_fill(input int c);
    applyStimulus(8'h82, 0);
    for (int i = 0; i < CELLS; i++)
      exp_q.push_back('{addr: i, data: c, fill: 1'b1, b2b: (i > 0)});
    mptr = 0;
    applyStimulus(c, 0);
  endtask

  task automatic send_junk(input int b);
    exp_err++;
    applyStimulus(b, 0);
  endtask

  task automatic random_payload(input int n);
    for (int i = 0; i < n; i++) payload.push_back(int'($urandom_range(0, 255)));
  endtask

  // Wait for all expected writes, then let error pulses settle; ends at posedge+1.
  task automatic wait_drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 3000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("drain_pending_writes", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    checkOutput("pending_err", exp_err, 0);
    exp_err = 0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int waited;
    int choice;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    reset_n      = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_we", 32'(bus.we), 0);
    checkOutput("reset_addr", 32'(bus.addr), 0);
    checkOutput("reset_wdata", 32'(bus.wdata), 0);
    checkOutput("reset_err", 32'(bus.err), 0);
    checkOutput("reset_busy", 32'(bus.busy), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    $display("[TB] fill with colour 0x30");
    cmd_fill(8'h30);
    waited = 0;
    while (exp_q.size() != 0 && waited < 3000) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checkOutput("fill_drained", exp_q.size(), 0);
    @(negedge clk);
    checkOutput("busy_after_fill", 32'(bus.busy), 0);
    checkOutput("in_ready_after_fill", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    $display("[TB] write burst at 266");
    cmd_set_addr(8'h01, 8'h0A);
    payload = '{8'h11, 8'h22, 8'h33};
    cmd_write(0);
    wait_drain();

    $display("[TB] write burst wrapping at 299");
    cmd_set_addr(8'h01, 8'h2B);
    payload = '{8'hAA, 8'hBB};
    cmd_write(0);
    wait_drain();

    $display("[TB] bad command and out-of-range address");
    send_junk(8'h05);
    cmd_set_addr(8'h01, 8'hFF);
    payload = '{8'h5A};
    cmd_write(0);
    wait_drain();

    $display("[TB] 256-byte burst with valid gaps");
    cmd_set_addr(0, int'($urandom_range(0, 255)));
    random_payload(256);
    cmd_write(3);
    wait_drain();

    $display("[TB] random command mix");
    for (int k = 0; k < 12; k++) begin
      choice = int'($urandom_range(0, 5));
      case (choice)
        0, 1: cmd_set_addr(int'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
        2, 3: begin
          random_payload(int'($urandom_range(1, 12)));
          cmd_write(int'($urandom_range(0, 2)));
        end
        4: send_junk(int'($urandom_range(0, 127)));
        default: cmd_fill(int'($urandom_range(0, 63)));
      endcase
    end
    wait_drain();

    $display("[TB] reset during fill");
    cmd_fill(8'h2C);
    waited = 0;
    forever begin
      @(negedge clk);
      if (bus.we === 1'b1 && bus.addr == 9'd100) break;
      waited++;
      if (waited > 1000) begin
        report_fail("fill_cell100_timeout", "cell 100 never written");
        break;
      end
    end
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    exp_err = 0;
    mptr = 0;
    @(negedge clk);
    checkOutput("abort_we", 32'(bus.we), 0);
    checkOutput("abort_busy", 32'(bus.busy), 0);
    checkOutput("abort_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("after_abort_we", 32'(bus.we), 0);
    @(posedge clk);
    #1;
    payload = '{8'h07};
    cmd_write(0);
    wait_drain();

    checkOutput("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_loader.md
TILE_LOADER -- requirements
Module: tile_loader

Interface
REQ-001 Parameter CELLS, default 300, number of tile cells (20x15 grid).
REQ-002 Parameter ADDR_W, default 9, tile address width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 in_data  input  8  command/data byte stream.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  loader accepts byte; transfer when in_valid & in_ready.
REQ-008 we  output  1  tile RAM write strobe, one cycle per write.
REQ-009 addr  output  ADDR_W  tile RAM write address.
REQ-010 wdata  output  8  tile RAM write data (colour byte, RRGGBB in bits 5:0).
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 err  output  1  one-cycle pulse on protocol error.

Function
REQ-013 The block SHALL decode a byte protocol: 0x80 SET_ADDR (2 operand bytes: addr[8], addr[7:0]); 0x81 WRITE (count byte N, then N data bytes; N=0 means 256); 0x82 FILL (1 colour byte, then writes all CELLS cells).
REQ-014 The FSM SHALL have states IDLE, ADDR_HI, ADDR_LO, COUNT, DATA, FILL.
REQ-015 Transitions: IDLE -0x80-> ADDR_HI -> ADDR_LO -> IDLE; IDLE -0x81-> COUNT -> DATA -(last byte)-> IDLE; IDLE -0x82-> (colour byte accepted in IDLE-sub-step COUNT-like capture) FILL -(cell CELLS-1 written)-> IDLE.
REQ-016 FILL colour byte SHALL be captured in the COUNT state (shared operand state, command code latched).
REQ-017 In IDLE, any byte other than 0x80/0x81/0x82 SHALL be dropped and err pulsed the following cycle.
REQ-018 in_ready SHALL be 1 in IDLE, ADDR_HI, ADDR_LO, COUNT, DATA and 0 in FILL.
REQ-019 Each byte accepted in DATA SHALL produce we=1 on the next cycle with addr = current write pointer, wdata = that byte; pointer then increments.
REQ-020 The write pointer SHALL wrap from CELLS-1 to 0.
REQ-021 SET_ADDR value >= CELLS SHALL load pointer 0 and pulse err.
REQ-022 FILL SHALL write cells 0..CELLS-1, one per cycle, exactly CELLS write cycles, then leave pointer = 0.
REQ-023 we SHALL be 0 whenever no write is issued; addr/wdata hold their last value.
REQ-024 Back-to-back accepted data bytes SHALL yield back-to-back we pulses (throughput 1 byte/cycle, latency 1 cycle).
REQ-025 Bytes with in_valid=0 SHALL not advance the FSM or counters.

Reset
REQ-026 On reset_n=0 at a rising edge: state=IDLE, pointer=0, count=0, we=0, addr=0, wdata=0, err=0, busy=0; in_ready=1 from the first cycle after release.
REQ-027 Reset asserted mid-WRITE or mid-FILL SHALL abort immediately; no further we pulse after the reset edge.

Structure
REQ-028 Shared package tile_pkg SHALL hold CMD_SET_ADDR/CMD_WRITE/CMD_FILL constants, CELLS default, and the state enum typedef.
REQ-029 Single module, no sub-modules; write strobe/address/data registered outputs.

Verification
REQ-030 Reset then 0x82,0x30 -> 300 consecutive we cycles, addr 0..299, wdata=0x30, in_ready=0 throughout, busy falls after addr 299.
REQ-031 0x80,0x01,0x0A (addr 266), 0x81,0x03,0x11,0x22,0x33 -> writes 266=0x11, 267=0x22, 268=0x33 on consecutive cycles.
REQ-032 0x80,0x01,0x2B (addr 299), 0x81,0x02,0xAA,0xBB -> writes 299=0xAA then 0=0xBB.
REQ-033 Bytes 0x05 then 0x80,0x01,0xFF (511) -> err pulse after 0x05, err pulse after 0xFF, pointer=0, no we.
REQ-034 0x81,0x00 then 256 bytes with random in_valid gaps -> exactly 256 we pulses, addr wrapping 0..299 then 0..? per pointer, none during gaps.
REQ-035 Reset asserted at FILL cell 100 -> we=0 from next cycle, state IDLE, following 0x81,0x01,0x07 writes addr 0=0x07.
